// File: rtl/reg_file_pkg.sv
// Shared types and constants for the context-switchable register file.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } ctx_state_t;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NGTV = 1;
  localparam int unsigned FLAG_SCRY = 2;

endpackage

// File: rtl/ctx_engine.sv
// Context save/restore sequencer: walks DEPTH registers plus one flag word
// through a request/acknowledge memory handshake.
module ctx_engine
  import reg_file_pkg::*;
#(
  parameter int unsigned PW = 3,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ctx_start,
  input  logic          ctx_restore,
  input  logic [AW-1:0] ctx_base,
  input  logic          mem_ack,
  output logic          ctx_busy,
  output logic          ctx_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [PW:0]   idx,
  output logic          reg_load,
  output logic          flag_load
);

  localparam int unsigned IW = PW + 1;

  ctx_state_t state;
  logic       restore;
  logic       handshake;

  // idx runs 0..2**PW, so its top bit alone marks the trailing flag word
  assign handshake = (state == XFER) && mem_ack;
  assign reg_load  = handshake && restore && !idx[PW];
  assign flag_load = handshake && restore && idx[PW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      restore  <= 1'b0;
      ctx_busy <= 1'b0;
      ctx_done <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          ctx_done <= 1'b0;
          if (ctx_start) begin
            state    <= XFER;
            idx      <= '0;
            restore  <= ctx_restore;
            ctx_busy <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= !ctx_restore;
            mem_addr <= ctx_base;
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (idx[PW]) begin
              state    <= DONE;
              ctx_busy <= 1'b0;
              ctx_done <= 1'b1;
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= '0;
            end else begin
              idx      <= idx + IW'(1);
              mem_addr <= mem_addr + AW'(1);
            end
          end
        end
        DONE: begin
          ctx_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_ctx.sv
// Parametrised register file with flag storage, optional write bypass and a
// context save/restore engine that spills or refills it through data memory.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned PW     = 3,
  parameter int unsigned NF     = 3,
  parameter int unsigned AW     = 8,
  parameter int unsigned BYPASS = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [PW-1:0] write_addr,
  input  logic [DW-1:0] write_data,
  input  logic [PW-1:0] read_addr_a,
  input  logic [PW-1:0] read_addr_b,
  output logic [DW-1:0] read_a,
  output logic [DW-1:0] read_b,
  input  logic          flag_we,
  input  logic [NF-1:0] flags_in,
  output logic [NF-1:0] flags_out,
  input  logic          ctx_start,
  input  logic          ctx_restore,
  input  logic [AW-1:0] ctx_base,
  output logic          ctx_busy,
  output logic          ctx_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int unsigned DEPTH = 2 ** PW;

  logic [DW-1:0] core [DEPTH];
  logic [NF-1:0] flags;
  logic [DW-1:0] flag_word;

  logic [PW:0]   idx;
  logic          reg_load;
  logic          flag_load;

  logic          st_we;
  logic [PW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_fwe;
  logic [NF-1:0] st_flags;
  logic          user_we;

  ctx_engine #(
    .PW(PW),
    .AW(AW)
  ) u_engine (
    .clk        (clk),
    .reset      (reset),
    .ctx_start  (ctx_start),
    .ctx_restore(ctx_restore),
    .ctx_base   (ctx_base),
    .mem_ack    (mem_ack),
    .ctx_busy   (ctx_busy),
    .ctx_done   (ctx_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .idx        (idx),
    .reg_load   (reg_load),
    .flag_load  (flag_load)
  );

  assign user_we = write_en && !ctx_busy;

  // Storage write port: the engine owns it while busy, the datapath otherwise
  always_comb begin
    if (ctx_busy) begin
      st_we    = reg_load;
      st_addr  = idx[PW-1:0];
      st_data  = mem_rdata;
      st_fwe   = flag_load;
      st_flags = mem_rdata[NF-1:0];
    end else begin
      st_we    = write_en;
      st_addr  = write_addr;
      st_data  = write_data;
      st_fwe   = flag_we;
      st_flags = flags_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        core[i] <= '0;
      end
      flags <= '0;
    end else begin
      if (st_we) begin
        core[st_addr] <= st_data;
      end
      if (st_fwe) begin
        flags <= st_flags;
      end
    end
  end

  always_comb begin
    read_a = core[read_addr_a];
    read_b = core[read_addr_b];
    if (BYPASS != 0 && user_we) begin
      if (read_addr_a == write_addr) read_a = write_data;
      if (read_addr_b == write_addr) read_b = write_data;
    end
  end

  assign flags_out = flags;

  always_comb begin
    flag_word          = '0;
    flag_word[NF-1:0]  = flags;
  end

  // Save data is read live from storage; it cannot move while busy because
  // datapath writes are blocked, and it picks up a write made on the start cycle
  always_comb begin
    mem_wdata = '0;
    if (mem_req && mem_we) begin
      mem_wdata = idx[PW] ? flag_word : core[idx[PW-1:0]];
    end
  end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Self-checking bench for reg_file_ctx with a behavioural register/memory model.
`timescale 1ns/100ps
module tb_reg_file_ctx;

  localparam int DW = 8, PW = 3, NF = 3, AW = 8, DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_en = 1'b0;
  logic [PW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [PW-1:0] read_addr_a = '0;
  logic [PW-1:0] read_addr_b = '0;
  logic          flag_we = 1'b0;
  logic [NF-1:0] flags_in = '0;
  logic          ctx_start = 1'b0;
  logic          ctx_restore = 1'b0;
  logic [AW-1:0] ctx_base = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  logic [DW-1:0] read_a, read_b, mem_wdata;
  logic [NF-1:0] flags_out;
  logic          ctx_busy, ctx_done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] byp_read_a, byp_read_b, byp_mem_wdata;
  logic [NF-1:0] byp_flags_out;
  logic          byp_ctx_busy, byp_ctx_done, byp_mem_req, byp_mem_we;
  logic [AW-1:0] byp_mem_addr;

  reg_file_ctx #(.DW(DW), .PW(PW), .NF(NF), .AW(AW), .BYPASS(0)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_a(read_a), .read_b(read_b), .flag_we(flag_we), .flags_in(flags_in),
    .flags_out(flags_out), .ctx_start(ctx_start), .ctx_restore(ctx_restore),
    .ctx_base(ctx_base), .ctx_busy(ctx_busy), .ctx_done(ctx_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  reg_file_ctx #(.DW(DW), .PW(PW), .NF(NF), .AW(AW), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_a(byp_read_a), .read_b(byp_read_b), .flag_we(flag_we), .flags_in(flags_in),
    .flags_out(byp_flags_out), .ctx_start(ctx_start), .ctx_restore(ctx_restore),
    .ctx_base(ctx_base), .ctx_busy(byp_ctx_busy), .ctx_done(byp_ctx_done),
    .mem_req(byp_mem_req), .mem_we(byp_mem_we), .mem_addr(byp_mem_addr),
    .mem_wdata(byp_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_regs [DEPTH];
  logic [NF-1:0] m_flags;
  logic [DW-1:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder state
  int            ack_mode = 0;
  int            ack_cnt  = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            stab_err  = 0;
  int            done_seen = 0;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] sv_addr;
  logic [DW-1:0] sv_wdata;
  logic          sv_we;

  // Decides the acknowledge for the coming edge and logs the handshake it implies
  always @(negedge clk) begin
    if (mem_req && stall_prev) begin
      if (mem_addr !== sv_addr || mem_wdata !== sv_wdata || mem_we !== sv_we) stab_err++;
    end
    ack_cnt++;
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = (ack_cnt % 3 == 0);
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase
    mem_rdata = mem[mem_addr];
    if (mem_req && mem_ack && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      mem[mem_addr] = mem_wdata;
    end
    stall_prev = mem_req && !mem_ack;
    sv_addr    = mem_addr;
    sv_wdata   = mem_wdata;
    sv_we      = mem_we;
    if (ctx_done) done_seen++;
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_flags = '0;
  endtask

  task automatic read_reg(input int a, output logic [DW-1:0] va, output logic [DW-1:0] vb);
    read_addr_a = PW'(a);
    read_addr_b = PW'(a);
    #1;
    va = read_a;
    vb = read_b;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic we,
                          input logic fwe, input logic [NF-1:0] f);
    @(negedge clk);
    write_en = we; write_addr = PW'(a); write_data = d;
    flag_we = fwe; flags_in = f;
    @(negedge clk);
    write_en = 1'b0; flag_we = 1'b0;
    if (we) m_regs[a] = d;
    if (fwe) m_flags = f;
  endtask

  // Runs one context operation; optional datapath write on the start cycle and
  // random datapath strobes while busy (which must be dropped)
  task automatic run_ctx(input logic restore, input logic [AW-1:0] base, input int mode,
                         input logic we0, input int wa0, input logic [DW-1:0] wd0,
                         input logic noise, output int cycles, output logic ok);
    @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    ack_mode = mode;
    ctx_start = 1'b1; ctx_restore = restore; ctx_base = base;
    write_en = we0; write_addr = PW'(wa0); write_data = wd0;
    if (we0) m_regs[wa0] = wd0;
    @(negedge clk);
    ctx_start = 1'b0; write_en = 1'b0;
    ok = 1'b0;
    for (cycles = 1; cycles < 400; cycles++) begin
      if (ctx_done) begin
        ok = 1'b1;
        break;
      end
      if (noise) begin
        write_en = 1'($urandom_range(0, 1)); flag_we = 1'($urandom_range(0, 1));
        write_addr = PW'($urandom); write_data = DW'($urandom); flags_in = NF'($urandom);
      end
      @(negedge clk);
      write_en = 1'b0; flag_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] va, vb;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_write(2, 8'h77, 1'b1, 1'b1, 3'b011);
    do_write(6, 8'h5A, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (flags_out !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %h want 0", flags_out); end
    n_checks++;
    if (mem_req !== 1'b0 || ctx_busy !== 1'b0 || ctx_done !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl got req=%b busy=%b done=%b we=%b want 0", mem_req, ctx_busy, ctx_done, mem_we);
    end
    n_checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    for (int i = 0; i < DEPTH; i++) begin
      read_reg(i, va, vb);
      n_checks++;
      if (va !== 8'h00 || vb !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got %h/%h want 0", i, va, vb); end
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    logic [DW-1:0] va, vb;
    int a;
    do_write(0, 8'h00, 1'b0, 1'b1, 3'b110);
    do_write(3, 8'hA5, 1'b1, 1'b0, 3'b001);
    read_reg(3, va, vb);
    n_checks++;
    if (va !== 8'hA5) begin n_fail++; $display("FAIL basic_r3 got %h want a5", va); end
    n_checks++;
    if (flags_out !== 3'b110) begin n_fail++; $display("FAIL basic_flags got %b want 110", flags_out); end
    for (int k = 0; k < 24; k++) begin
      do_write($urandom_range(0, DEPTH - 1), DW'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), NF'($urandom));
      a = $urandom_range(0, DEPTH - 1);
      read_reg(a, va, vb);
      n_checks++;
      if (va !== m_regs[a] || vb !== m_regs[a] || flags_out !== m_flags) begin
        n_fail++; $display("FAIL basic_rand r%0d got %h/%h flags %b want %h flags %b", a, va, vb, flags_out, m_regs[a], m_flags);
      end
    end
  endtask

  task automatic test_bypass();
    do_write(5, 8'h11, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    write_en = 1'b1; write_addr = 3'd5; write_data = 8'h3C;
    read_addr_b = 3'd5; read_addr_a = 3'd2;
    #1;
    n_checks++;
    if (byp_read_b !== 8'h3C) begin n_fail++; $display("FAIL bypass_fwd got %h want 3c", byp_read_b); end
    n_checks++;
    if (read_b !== 8'h11) begin n_fail++; $display("FAIL bypass_off got %h want 11", read_b); end
    n_checks++;
    if (byp_read_a !== m_regs[2]) begin n_fail++; $display("FAIL bypass_nomatch got %h want %h", byp_read_a, m_regs[2]); end
    @(posedge clk);
    #1;
    n_checks++;
    if (read_b !== 8'h3C) begin n_fail++; $display("FAIL bypass_after_edge got %h want 3c", read_b); end
    @(negedge clk);
    write_en = 1'b0;
    m_regs[5] = 8'h3C;
  endtask

  task automatic test_save();
    int cycles;
    logic ok;
    do_write(0, 8'h99, 1'b1, 1'b1, 3'b101);
    for (int i = 1; i < DEPTH; i++) do_write(i, DW'(8'h10 + i), 1'b1, 1'b0, 3'b000);
    run_ctx(1'b0, 8'h40, 0, 1'b1, 0, 8'h10, 1'b0, cycles, ok);
    n_checks++;
    if (!ok || cycles != 10) begin n_fail++; $display("FAIL save_done_cycle got %0d (ok=%b) want 10", cycles, ok); end
    @(negedge clk);
    n_checks++;
    if (ctx_done !== 1'b0 || ctx_busy !== 1'b0) begin n_fail++; $display("FAIL save_done_width got done=%b busy=%b want 0", ctx_done, ctx_busy); end
    n_checks++;
    if (wr_addr_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL save_count got %0d want %0d", wr_addr_q.size(), DEPTH + 1); end
    for (int i = 0; i < wr_addr_q.size() && i <= DEPTH; i++) begin
      n_checks++;
      if (wr_addr_q[i] !== AW'(8'h40 + i) || wr_data_q[i] !== ((i == DEPTH) ? 8'h05 : DW'(8'h10 + i))) begin
        n_fail++; $display("FAIL save_word%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i],
                           (i == DEPTH) ? 8'h05 : DW'(8'h10 + i), AW'(8'h40 + i));
      end
    end
  endtask

  task automatic test_restore();
    int cycles;
    logic ok;
    logic [DW-1:0] va, vb;
    for (int i = 0; i < DEPTH; i++) mem[8'h80 + i] = DW'(8'hF0 + i);
    mem[8'h88] = 8'h02;
    stab_err = 0;
    run_ctx(1'b1, 8'h80, 1, 1'b0, 0, 8'h00, 1'b1, cycles, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL restore_timeout got %0d cycles want done", cycles); end
    for (int i = 0; i < DEPTH; i++) m_regs[i] = DW'(8'hF0 + i);
    m_flags = 3'b010;
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL restore_stall_stable got %0d changes want 0", stab_err); end
    n_checks++;
    if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL restore_no_writes got %0d want 0", wr_addr_q.size()); end
    n_checks++;
    if (flags_out !== 3'b010) begin n_fail++; $display("FAIL restore_flags got %b want 010", flags_out); end
    for (int i = 0; i < DEPTH; i++) begin
      read_reg(i, va, vb);
      n_checks++;
      if (va !== m_regs[i]) begin n_fail++; $display("FAIL restore_r%0d got %h want %h", i, va, m_regs[i]); end
    end
  endtask

  task automatic test_wrap();
    int cycles;
    logic ok;
    logic [AW-1:0] ea;
    run_ctx(1'b0, 8'hFC, 2, 1'b0, 0, 8'h00, 1'b0, cycles, ok);
    n_checks++;
    if (!ok || wr_addr_q.size() != DEPTH + 1) begin
      n_fail++; $display("FAIL wrap_count got %0d (ok=%b) want %0d", wr_addr_q.size(), ok, DEPTH + 1);
    end
    for (int i = 0; i < wr_addr_q.size() && i <= DEPTH; i++) begin
      ea = AW'(8'hFC + i);
      n_checks++;
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== ((i == DEPTH) ? DW'(m_flags) : m_regs[i])) begin
        n_fail++; $display("FAIL wrap_word%0d got %h@%h want %h@%h", i, wr_data_q[i], wr_addr_q[i],
                           (i == DEPTH) ? DW'(m_flags) : m_regs[i], ea);
      end
    end
  endtask

  task automatic test_abort();
    int cycles;
    logic ok;
    logic [DW-1:0] va, vb;
    @(negedge clk);
    ack_mode = 0;
    ctx_start = 1'b1; ctx_restore = 1'b0; ctx_base = 8'h20;
    @(negedge clk);
    ctx_start = 1'b0;
    done_seen = 0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (mem_addr !== 8'h24 || mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_pos got req=%b addr=%h want 1/24", mem_req, mem_addr); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || ctx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_req got req=%b busy=%b want 0", mem_req, ctx_busy); end
    for (int i = 0; i < DEPTH; i++) begin
      read_reg(i, va, vb);
      n_checks++;
      if (va !== 8'h00) begin n_fail++; $display("FAIL abort_r%0d got %h want 0", i, va); end
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (12) @(negedge clk);
    n_checks++;
    if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
    do_write(4, 8'hC3, 1'b1, 1'b1, 3'b100);
    run_ctx(1'b0, 8'h30, 2, 1'b0, 0, 8'h00, 1'b0, cycles, ok);
    n_checks++;
    if (!ok || wr_addr_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL abort_rerun got %0d words (ok=%b) want 9", wr_addr_q.size(), ok); end
    n_checks++;
    if (mem[8'h34] !== 8'hC3 || mem[8'h38] !== 8'h04 || mem[8'h30] !== 8'h00) begin
      n_fail++; $display("FAIL abort_rerun_data got %h %h %h want c3 04 00", mem[8'h34], mem[8'h38], mem[8'h30]);
    end
  endtask

  task automatic test_random_roundtrip();
    int cycles;
    logic ok;
    logic [AW-1:0] base;
    logic [DW-1:0] saved [DEPTH];
    logic [NF-1:0] saved_f;
    logic [DW-1:0] va, vb;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom), 1'b1, 1'b0, 3'b000);
      do_write(0, m_regs[0], 1'b0, 1'b1, NF'($urandom));
      for (int i = 0; i < DEPTH; i++) saved[i] = m_regs[i];
      saved_f = m_flags;
      base = AW'($urandom);
      run_ctx(1'b0, base, 2, 1'b0, 0, 8'h00, 1'b1, cycles, ok);
      for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom), 1'b1, 1'b1, NF'($urandom));
      run_ctx(1'b1, base, $urandom_range(0, 2), 1'b0, 0, 8'h00, 1'b1, cycles, ok);
      n_checks++;
      if (!ok || flags_out !== saved_f) begin n_fail++; $display("FAIL rt%0d_flags got %b (ok=%b) want %b", r, flags_out, ok, saved_f); end
      for (int i = 0; i < DEPTH; i++) begin
        read_reg(i, va, vb);
        n_checks++;
        if (vb !== saved[i]) begin n_fail++; $display("FAIL rt%0d_r%0d got %h want %h", r, i, vb, saved[i]); end
        m_regs[i] = saved[i];
      end
      m_flags = saved_f;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    model_clear();
    test_reset();
    test_basic();
    test_bypass();
    test_save();
    test_restore();
    test_wrap();
    test_abort();
    test_random_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_ctx.md
Name: reg_file_ctx

Overview:
- Parametrised successor to the 8-entry, 8-bit core register file with flag storage.
- Adds configurable data width, depth and flag count, an optional write-to-read bypass, and an independent flag write enable.
- Adds a context save/restore engine that spills the whole register file plus flags to data memory, or refills it, one word per handshake.
- Sits between the decode/ALU datapath and the data-memory arbiter; used for interrupt/call context switching.

Parameters:
- DW, 8, data word width (bits).
- PW, 3, register address width; DEPTH = 2**PW entries.
- NF, 3, number of flag bits; must satisfy NF <= DW. Bit 0 = zero, bit 1 = negative, bit 2 = shift-carry.
- AW, 8, data-memory address width.
- BYPASS, 0, when 1, a same-cycle write forwards to matching read ports.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- write_en, in, 1, register write strobe.
- write_addr, in, PW, register write pointer.
- write_data, in, DW, register write data.
- read_addr_a, in, PW, read pointer A.
- read_addr_b, in, PW, read pointer B.
- read_a, out, DW, read data A.
- read_b, out, DW, read data B.
- flag_we, in, 1, flag write strobe, independent of write_en.
- flags_in, in, NF, flag values from the ALU.
- flags_out, out, NF, stored flags.
- ctx_start, in, 1, one-cycle pulse that starts a context operation.
- ctx_restore, in, 1, sampled with ctx_start: 0 = save, 1 = restore.
- ctx_base, in, AW, memory base address, sampled with ctx_start.
- ctx_busy, out, 1, high while the engine is active.
- ctx_done, out, 1, one-cycle completion pulse.
- mem_req, out, 1, memory request.
- mem_we, out, 1, 1 = write, 0 = read.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data; valid in the cycle mem_ack is high.
- mem_ack, in, 1, memory acknowledge.

Behaviour:
- Reset (async, immediate):
  - all DEPTH entries and flags clear to 0;
  - FSM goes to IDLE;
  - ctx_busy, ctx_done, mem_req, mem_we are 0; mem_addr and mem_wdata are 0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- Reads are combinational: read_a = core[read_addr_a], read_b likewise.
- With BYPASS=1, write_en high and read_addr == write_addr, the read port returns write_data. With BYPASS=0, the old value is returned until the next edge.
- Writes: on posedge, write_en updates core[write_addr]; flag_we updates flags. The two strobes are fully independent.
- While ctx_busy, write_en and flag_we are ignored. Reads stay live and show the registers as they are being restored.
- FSM states and transitions:
  - IDLE: on ctx_start, latch ctx_base and ctx_restore, clear index i to 0, and go to XFER. ctx_busy rises in the next cycle.
  - XFER: mem_req = 1 and mem_addr = base + i (modulo 2**AW, wraps).
    - Save: mem_we = 1; mem_wdata = core[i] for i < DEPTH; for i = DEPTH, mem_wdata = flags zero-extended to DW.
    - Restore: mem_we = 0; on mem_ack, core[i] <= mem_rdata, or flags <= mem_rdata[NF-1:0] when i = DEPTH.
    - On mem_ack: if i == DEPTH, go to DONE; otherwise i <= i + 1. i is PW+1 bits wide.
    - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack.
  - DONE: ctx_done = 1 for exactly one cycle, ctx_busy = 0, return to IDLE.
- Transfer length and latency:
  - A transfer is DEPTH+1 words.
  - With mem_ack tied high, the operation takes DEPTH+1 XFER cycles plus 1 DONE cycle.
- ctx_start while busy or in DONE is ignored.
- mem_ack while mem_req is low is ignored.
- A write_en and ctx_start in the same IDLE cycle: the write is performed, then the save captures the written value.

Decomposition:
- Package reg_file_pkg holds:
  - ctx_state_t enum {IDLE, XFER, DONE};
  - flag bit index constants FLAG_ZERO = 0, FLAG_NGTV = 1, FLAG_SCRY = 2.
- One sub-module, ctx_engine: holds the FSM, index counter, and memory handshake.
- It drives the storage write port through an internal override mux (addr, data, we, flag_we) in reg_file_ctx.

Test Plan:
- Reset and basic access: assert reset mid-cycle → all reads and flags_out = 0 immediately. Then write 8'hA5 to r3 → the next cycle read_a(r3) = A5, with flags unchanged because flag_we = 0.
- Bypass: BYPASS=1, write 8'h3C to r5 while read_addr_b = 5 → read_b = 3C in the same cycle. With BYPASS=0 → read_b shows the old value, then 3C after the edge.
- Save: preload r0..r7 = 10..17 and flags = 3'b101; ctx_start, save, base 8'h40, mem_ack always 1 → writes 40..47 = 10..17 and 48 = 05. ctx_done pulses in cycle 10.
- Restore with stalls: memory 0x80..0x88 = F0..F7 and 8'h02, ack every third cycle → r0..r7 = F0..F7 and flags = 3'b010. Request signals are stable across stalls. write_en pulses during busy are dropped.
- Address wrap: base 8'hFC, save → addresses FC, FD, FE, FF, 00, 01, 02, 03, 04.
- Abort: reset during XFER at i = 4 → mem_req = 0 at once, registers = 0, no ctx_done pulse. A new ctx_start afterwards completes normally.
